// File: rtl/cache_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared cache FSM.
// One request is in flight at a time; the cache result is steered back to its owner.
package cache_req_arbiter_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

endpackage

module cache_req_arbiter
    import cache_req_arbiter_pkg::*;
#(
    parameter bit          PRIO_RESET  = 1'b0,
    parameter int unsigned HANG_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  cpu_req_type    req0,
    input  cpu_req_type    req1,
    output cpu_result_type res0,
    output cpu_result_type res1,
    output cpu_req_type    cache_req,
    input  cpu_result_type cache_res,
    output logic [1:0]     grant,
    output logic           hang
);

    localparam bit          HANG_EN    = (HANG_CYCLES != 0);
    localparam logic [15:0] HANG_LIMIT = HANG_CYCLES[15:0];

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t      state;
    logic        ptr;
    logic [15:0] wait_cnt;

    logic        pick;
    cpu_req_type winner;
    logic [15:0] wait_cnt_next;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        pick = 1'b0;
        if (req0.valid && req1.valid) begin
            pick = ptr;
        end else if (req1.valid) begin
            pick = 1'b1;
        end
        winner        = pick ? req1 : req0;
        wait_cnt_next = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PRIO_RESET;
            cache_req <= '0;
            grant     <= 2'b00;
            wait_cnt  <= '0;
            hang      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The selected requester is valid by construction, so its valid bit is forwarded as-is.
                    if (req0.valid || req1.valid) begin
                        cache_req <= winner;
                        grant     <= pick ? 2'b10 : 2'b01;
                        ptr       <= ~pick;
                        wait_cnt  <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cache_res.ready) begin
                        cache_req <= '0;
                        grant     <= 2'b00;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt_next;
                        if (HANG_EN && (wait_cnt_next == HANG_LIMIT)) begin
                            hang <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Results are combinational so the owner sees ready in the same cycle the cache raises it.
    always_comb begin
        res0 = '0;
        res1 = '0;
        if ((state == WAIT) && cache_res.ready) begin
            if (grant[0]) begin
                res0.data  = cache_res.data;
                res0.ready = 1'b1;
            end
            if (grant[1]) begin
                res1.data  = cache_res.data;
                res1.ready = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cache_req_arbiter;
    import cache_req_arbiter_pkg::*;

    localparam bit PRIO = 1'b0;
    localparam int HANG = 8;

    logic           clk = 1'b0;
    logic           rst;
    cpu_req_type    req0, req1, cache_req;
    cpu_result_type res0, res1, cache_res;
    logic [1:0]     grant;
    logic           hang;

    cache_req_arbiter #(
        .PRIO_RESET (PRIO),
        .HANG_CYCLES(HANG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .res0     (res0),
        .res1     (res1),
        .cache_req(cache_req),
        .cache_res(cache_res),
        .grant    (grant),
        .hang     (hang)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the in-flight transaction, what it carries, how long it has waited.
    bit          m_live  = 1'b0;
    int          m_owner = -1;
    int          m_ptr   = 0;
    int          m_age   = 0;
    bit          m_hang  = 1'b0;
    cpu_req_type m_req   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_live  = 1'b1;
            m_owner = -1;
            m_ptr   = PRIO;
            m_age   = 0;
            m_hang  = 1'b0;
            m_req   = '0;
        end else if (m_owner < 0) begin
            if (req0.valid && req1.valid) m_owner = m_ptr;
            else if (req0.valid)          m_owner = 0;
            else if (req1.valid)          m_owner = 1;
            if (m_owner >= 0) begin
                m_req = (m_owner == 0) ? req0 : req1;
                m_ptr = 1 - m_owner;
                m_age = 0;
            end
        end else if (cache_res.ready) begin
            m_owner = -1;
        end else begin
            if (m_age < 65535) m_age++;
            if (HANG != 0 && m_age >= HANG) m_hang = 1'b1;
        end
    end

    int             cyc        = 0;
    int             last_ready = -100;
    logic [1:0]     prev_grant = 2'b00;
    logic           prev_valid = 1'b0;
    logic [1:0]     grant_log[$];
    cpu_req_type    e_req;
    cpu_result_type e_res0, e_res1;
    logic [1:0]     e_grant;

    always @(negedge clk) begin
        cyc++;
        if (m_live) begin
            e_req   = '0;
            e_res0  = '0;
            e_res1  = '0;
            e_grant = 2'b00;
            if (m_owner >= 0) begin
                e_req   = m_req;
                e_grant = (m_owner == 0) ? 2'b01 : 2'b10;
            end
            if (m_owner == 0 && cache_res.ready) e_res0 = {cache_res.data, 1'b1};
            if (m_owner == 1 && cache_res.ready) e_res1 = {cache_res.data, 1'b1};
            check("cache_req", cache_req, e_req);
            check("grant", grant, e_grant);
            check("res0", res0, e_res0);
            check("res1", res1, e_res1);
            check("hang", hang, m_hang);
            if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
            if (cache_req.valid && !prev_valid) check("spacing", (cyc - last_ready) >= 2, 1'b1);
            if (cache_res.ready && grant != 2'b00) last_ready = cyc;
            prev_grant = grant;
            prev_valid = cache_req.valid;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cache responder: waits for a request, then answers after `delay` extra cycles.
    task automatic serve(input logic [31:0] d, input int delay);
        int n;
        n = 0;
        while (!cache_req.valid && n < 20) begin
            tick();
            n++;
        end
        check("serve_timeout", n < 20, 1'b1);
        if (delay > 0) tick(delay);
        cache_res = {d, 1'b1};
        tick();
        cache_res = '0;
    endtask

    cpu_req_type x_req;

    initial begin
        rst       = 1'b1;
        req0      = '0;
        req1      = '0;
        cache_res = '0;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_res0", res0, '0);
        check("rst_res1", res1, '0);
        check("rst_grant", grant, 2'b00);
        check("rst_cache_req", cache_req, '0);
        check("rst_hang", hang, 1'b0);

        // Single read from requester 0, answered in its third WAIT cycle.
        tick();
        req0 = {32'h0000_1230, 32'h0, 1'b0, 1'b1};
        tick();
        @(negedge clk);
        check("single_valid", cache_req.valid, 1'b1);
        check("single_grant", grant, 2'b01);
        tick();
        tick();
        cache_res = {32'hCAFE_F00D, 1'b1};
        @(negedge clk);
        check("single_res0", res0, {32'hCAFE_F00D, 1'b1});
        check("single_res1", res1, '0);
        tick();
        cache_res = '0;
        req0      = '0;
        @(negedge clk);
        check("single_idle_grant", grant, 2'b00);
        check("single_idle_valid", cache_req.valid, 1'b0);

        // Spurious ready while idle.
        tick();
        cache_res = {32'h5555_AAAA, 1'b1};
        @(negedge clk);
        check("spur_res0", res0, '0);
        check("spur_res1", res1, '0);
        tick();
        cache_res = '0;
        @(negedge clk);
        check("spur_grant", grant, 2'b00);
        check("spur_cache_req", cache_req, '0);

        // Contention right after reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        grant_log.delete();
        req0 = {32'h0000_00A0, 32'h0000_0001, 1'b0, 1'b1};
        req1 = {32'h0000_00B0, 32'h0000_0002, 1'b1, 1'b1};
        serve(32'h1111_0000, 0);
        serve(32'h1111_0001, 0);
        serve(32'h1111_0002, 1);
        serve(32'h1111_0003, 2);
        req0 = '0;
        req1 = '0;
        tick(2);
        check("rr_count", grant_log.size(), 4);
        check("rr_g0", grant_log[0], 2'b01);
        check("rr_g1", grant_log[1], 2'b10);
        check("rr_g2", grant_log[2], 2'b01);
        check("rr_g3", grant_log[3], 2'b10);

        // Write pass-through from requester 1; valid dropped mid-WAIT.
        x_req = {32'h0004_0010, 32'h1234_5678, 1'b1, 1'b1};
        req1  = x_req;
        tick();
        @(negedge clk);
        check("wr_cache_req", cache_req, x_req);
        check("wr_grant", grant, 2'b10);
        tick();
        req1 = '0;
        tick();
        cache_res = {32'h0BAD_BEEF, 1'b1};
        @(negedge clk);
        check("wr_res1", res1, {32'h0BAD_BEEF, 1'b1});
        check("wr_res0", res0, '0);
        check("wr_held", cache_req, x_req);
        tick();
        cache_res = '0;

        // Reset during WAIT cycle 2; pointer must come back to PRIO_RESET.
        tick();
        req0 = {32'h0000_0300, 32'h0000_0007, 1'b0, 1'b1};
        tick();
        tick();
        rst  = 1'b1;
        req0 = '0;
        req1 = {32'h0000_0400, 32'h0000_0008, 1'b0, 1'b1};
        tick();
        rst       = 1'b0;
        req1      = '0;
        cache_res = {32'hDEAD_0001, 1'b1};
        @(negedge clk);
        check("rstw_res0", res0, '0);
        check("rstw_res1", res1, '0);
        check("rstw_grant", grant, 2'b00);
        tick();
        cache_res = '0;
        req0 = {32'h0000_0500, 32'h0000_0009, 1'b0, 1'b1};
        req1 = {32'h0000_0600, 32'h0000_000A, 1'b1, 1'b1};
        tick();
        @(negedge clk);
        check("rstw_next_grant", grant, 2'b01);
        serve(32'h2222_0000, 0);
        req0 = '0;
        req1 = '0;
        tick(2);

        // Hang: cache never answers.
        x_req = {32'h0000_0900, 32'h0000_0011, 1'b1, 1'b1};
        req0  = x_req;
        tick();
        tick(7);
        @(negedge clk);
        check("hang_before", hang, 1'b0);
        tick();
        @(negedge clk);
        check("hang_set", hang, 1'b1);
        check("hang_held_req", cache_req, x_req);
        tick(3);
        @(negedge clk);
        check("hang_sticky", hang, 1'b1);
        check("hang_fsm_grant", grant, 2'b01);
        rst  = 1'b1;
        req0 = '0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("hang_clear", hang, 1'b0);
        check("hang_rst_valid", cache_req.valid, 1'b0);
        check("hang_rst_grant", grant, 2'b00);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
